deadlock_report_arbiter: RTL and testbench

Central arbitration stage for the co-simulation deadlock monitor: consumes the per-process `dl_in_vec` flags raised by the per-process detect units and drives back the global `dl_detect_out`, one-hot `origin` and `token_clear` they consume. Selects a single originating process, freezes the detect units while the loop is confirmed, and either latches a sticky report or releases on a false alarm. Synthesizable; sits between the detect-unit ring and the testbench's reporting/finish logic.

---
 rtl/deadlock_report_arbiter.sv | 163 ++++++++++++++++
 tb/tb_deadlock_report_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/deadlock_report_arbiter.sv
// deadlock_report_arbiter
// Central arbitration stage for the co-simulation deadlock monitor.
// Picks the lowest-index suspect process, freezes the detect ring while the
// loop is confirmed, then latches a sticky report or releases on a false alarm.
// Every output is a flop; dl_in_vec only reaches next-state logic.
module deadlock_report_arbiter #(
    parameter int          PROC_NUM       = 2,
    parameter int          CONFIRM_CYCLES = 4,
    parameter int          IDX_W          = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1,
    // Reset value of the free-running cycle counter; lets wrap behaviour be
    // exercised without running 2^32 cycles. Leave at 0 in production.
    parameter logic [31:0] CYCLE_CNT_INIT = 32'd0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    output logic                dl_detect_out,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic                report_valid,
    output logic [IDX_W-1:0]    report_idx,
    output logic [31:0]         detect_cycle,
    output logic [7:0]          false_alarms
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOCK     = 2'd1,
        S_RELEASE  = 2'd2,
        S_REPORTED = 2'd3
    } state_t;

    localparam logic [7:0] CONF_TARGET = CONFIRM_CYCLES[7:0];

    state_t              state_q, state_d;
    logic [31:0]         cycle_cnt_q;
    logic [7:0]          confirm_cnt_q, confirm_cnt_d;
    logic [PROC_NUM-1:0] origin_q, origin_d;
    logic                dl_detect_q, dl_detect_d;
    logic                token_clear_q, token_clear_d;
    logic                report_valid_q, report_valid_d;
    logic [IDX_W-1:0]    report_idx_q, report_idx_d;
    logic [31:0]         detect_cycle_q, detect_cycle_d;
    logic [7:0]          false_alarms_q, false_alarms_d;

    logic [PROC_NUM-1:0] low_onehot;
    logic [IDX_W-1:0]    origin_idx;
    logic                any_flag;
    logic                origin_hit;
    logic                confirm_done;

    // Isolate the lowest set flag (two's complement trick) and decode the
    // binary index of the currently held origin.
    always_comb begin
        low_onehot = dl_in_vec & (~dl_in_vec + {{(PROC_NUM-1){1'b0}}, 1'b1});
        origin_idx = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (origin_q[i]) origin_idx = IDX_W'(i);
        end
    end

    assign any_flag     = |dl_in_vec;
    assign origin_hit   = |(dl_in_vec & origin_q);
    assign confirm_done = (confirm_cnt_q + 8'd1) == CONF_TARGET;

    // Free-running cycle counter; wraps naturally at 32 bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cycle_cnt_q <= CYCLE_CNT_INIT;
        else        cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a dropped origin flag beats reaching the target.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (any_flag) state_d = S_LOCK;
            S_LOCK: begin
                if (!origin_hit)       state_d = S_RELEASE;
                else if (confirm_done) state_d = S_REPORTED;
            end
            S_RELEASE:  state_d = S_IDLE;
            S_REPORTED: state_d = S_REPORTED;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output next values, registered below so outputs change on the edge
    // that performs the matching state transition.
    always_comb begin
        confirm_cnt_d  = confirm_cnt_q;
        origin_d       = origin_q;
        dl_detect_d    = dl_detect_q;
        token_clear_d  = 1'b0;
        report_valid_d = report_valid_q;
        report_idx_d   = report_idx_q;
        detect_cycle_d = detect_cycle_q;
        false_alarms_d = false_alarms_q;
        case (state_q)
            S_IDLE: begin
                confirm_cnt_d = 8'd0;
                if (any_flag) begin
                    origin_d       = low_onehot;
                    dl_detect_d    = 1'b1;
                    token_clear_d  = 1'b1;
                    detect_cycle_d = cycle_cnt_q;
                end
            end
            S_LOCK: begin
                if (!origin_hit) begin
                    origin_d      = '0;
                    dl_detect_d   = 1'b0;
                    token_clear_d = 1'b1;
                    if (false_alarms_q != 8'hFF) false_alarms_d = false_alarms_q + 8'd1;
                end else begin
                    confirm_cnt_d = confirm_cnt_q + 8'd1;
                    if (confirm_done) begin
                        report_valid_d = 1'b1;
                        report_idx_d   = origin_idx;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            confirm_cnt_q  <= 8'd0;
            origin_q       <= '0;
            dl_detect_q    <= 1'b0;
            token_clear_q  <= 1'b0;
            report_valid_q <= 1'b0;
            report_idx_q   <= '0;
            detect_cycle_q <= 32'd0;
            false_alarms_q <= 8'd0;
        end else begin
            confirm_cnt_q  <= confirm_cnt_d;
            origin_q       <= origin_d;
            dl_detect_q    <= dl_detect_d;
            token_clear_q  <= token_clear_d;
            report_valid_q <= report_valid_d;
            report_idx_q   <= report_idx_d;
            detect_cycle_q <= detect_cycle_d;
            false_alarms_q <= false_alarms_d;
        end
    end

    assign dl_detect_out = dl_detect_q;
    assign origin        = origin_q;
    assign token_clear   = token_clear_q;
    assign report_valid  = report_valid_q;
    assign report_idx    = report_idx_q;
    assign detect_cycle  = detect_cycle_q;
    assign false_alarms  = false_alarms_q;

endmodule

// File: tb/tb_deadlock_report_arbiter.sv
// Bench for deadlock_report_arbiter: directed steps followed by random
// episodes, all checked against a per-edge behavioural model of the monitor.
module tb_deadlock_report_arbiter;

    localparam int          P    = 2;
    localparam int          C    = 4;
    localparam logic [31:0] INIT = 32'hFFFF_FFF0;

    logic         clock, reset;
    logic [P-1:0] dl_in_vec;
    logic         dl_detect_out, token_clear, report_valid;
    logic [P-1:0] origin;
    logic [0:0]   report_idx;
    logic [31:0]  detect_cycle;
    logic [7:0]   false_alarms;

    logic         w_dl_detect_out, w_token_clear, w_report_valid;
    logic [P-1:0] w_origin;
    logic [0:0]   w_report_idx;
    logic [31:0]  w_detect_cycle;
    logic [7:0]   w_false_alarms;

    deadlock_report_arbiter #(.PROC_NUM(P), .CONFIRM_CYCLES(C)) dut (
        .clock(clock), .reset(reset), .dl_in_vec(dl_in_vec),
        .dl_detect_out(dl_detect_out), .origin(origin), .token_clear(token_clear),
        .report_valid(report_valid), .report_idx(report_idx),
        .detect_cycle(detect_cycle), .false_alarms(false_alarms)
    );

    // Same stimulus, counter started just below the wrap point.
    deadlock_report_arbiter #(.PROC_NUM(P), .CONFIRM_CYCLES(C), .CYCLE_CNT_INIT(INIT)) dut_w (
        .clock(clock), .reset(reset), .dl_in_vec(dl_in_vec),
        .dl_detect_out(w_dl_detect_out), .origin(w_origin), .token_clear(w_token_clear),
        .report_valid(w_report_valid), .report_idx(w_report_idx),
        .detect_cycle(w_detect_cycle), .false_alarms(w_false_alarms)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: which process is locked, how long its flag has been
    // held since the lock, whether a release cycle or a report is in effect.
    bit          m_lock, m_rel, m_rep, m_tc;
    int          m_idx, m_streak, m_fa;
    logic [31:0] m_cnt, m_cntw, m_det, m_detw;

    task automatic model_reset();
        m_lock = 0; m_rel = 0; m_rep = 0; m_tc = 0;
        m_idx = 0; m_streak = 0; m_fa = 0;
        m_cnt = 32'd0; m_cntw = INIT; m_det = 32'd0; m_detw = 32'd0;
    endtask

    task automatic model_edge(input logic [P-1:0] v);
        m_tc = 0;
        if (m_rep) begin
        end else if (m_rel) begin
            m_rel = 0;
        end else if (m_lock) begin
            if (v[m_idx]) begin
                m_streak++;
                if (m_streak == C) m_rep = 1;
            end else begin
                m_lock = 0; m_rel = 1; m_tc = 1;
                if (m_fa < 255) m_fa++;
            end
        end else if (v != 0) begin
            m_idx = 0;
            while (!v[m_idx]) m_idx++;
            m_lock = 1; m_streak = 0; m_tc = 1;
            m_det = m_cnt; m_detw = m_cntw;
        end
        m_cnt = m_cnt + 1;
        m_cntw = m_cntw + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [P-1:0] eo;
        eo = '0;
        if (m_lock) eo[m_idx] = 1'b1;
        chk("dl_detect_out", 32'(dl_detect_out), 32'(m_lock));
        chk("origin",        32'(origin),        32'(eo));
        chk("token_clear",   32'(token_clear),   32'(m_tc));
        chk("report_valid",  32'(report_valid),  32'(m_rep));
        chk("report_idx",    32'(report_idx),    m_rep ? 32'(m_idx) : 32'd0);
        chk("detect_cycle",  detect_cycle,       m_det);
        chk("false_alarms",  32'(false_alarms),  32'(m_fa));
        chk("detect_cycle_wrap", w_detect_cycle, m_detw);
    endtask

    // One clock: drive, let the edge happen, advance the model, check #1 later.
    task automatic cyc(input logic [P-1:0] v);
        dl_in_vec = v;
        @(posedge clock);
        model_edge(v);
        #1;
        check_all();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        dl_in_vec = 2'b11;
        model_reset();
        repeat (n) begin
            @(posedge clock);
            #1;
            check_all();
        end
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        dl_in_vec = '0;
        model_reset();
        #1;

        // Reset with both flags up: everything stays clear.
        do_reset(3);

        // Simultaneous flags sampled at cycle_cnt == 10.
        repeat (10) cyc(2'b00);
        cyc(2'b11);
        chk("tp_lock_origin", 32'(origin), 32'd1);
        chk("tp_lock_tc", 32'(token_clear), 32'd1);
        repeat (C) cyc(2'b11);
        chk("tp_report_valid", 32'(report_valid), 32'd1);
        chk("tp_detect_cycle", detect_cycle, 32'd10);
        repeat (3) cyc(2'b00);

        // False alarm on process 1.
        do_reset(2);
        cyc(2'b10);
        chk("fa_origin", 32'(origin), 32'd2);
        cyc(2'b10);
        cyc(2'b00);
        cyc(2'b00);
        cyc(2'b00);
        chk("fa_count", 32'(false_alarms), 32'd1);

        // Origin drops exactly when the counter would hit its target.
        cyc(2'b01);
        repeat (C - 1) cyc(2'b01);
        cyc(2'b10);
        cyc(2'b00);
        cyc(2'b00);
        chk("drop_no_report", 32'(report_valid), 32'd0);

        // Saturating false alarm counter; also carries dut_w across its wrap.
        repeat (300) begin
            cyc(2'b10);
            cyc(2'b00);
            cyc(2'b00);
        end
        chk("fa_saturate", 32'(false_alarms), 32'd255);

        // Reset while REPORTED clears asynchronously, then a fresh report.
        cyc(2'b01);
        repeat (C) cyc(2'b01);
        chk("rep_before_reset", 32'(report_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        check_all();
        reset = 1'b1;
        repeat (2) cyc(2'b00);
        cyc(2'b10);
        repeat (C) cyc(2'b10);
        chk("rep_after_reset", 32'(report_valid), 32'd1);
        chk("rep_idx_after_reset", 32'(report_idx), 32'd1);

        // Random episodes: flag patterns held for random lengths.
        repeat (150) begin
            logic [P-1:0] v;
            int len;
            v = P'($urandom_range(0, 3));
            len = $urandom_range(1, 7);
            repeat (len) cyc(v);
            if (m_rep && ($urandom_range(0, 2) == 0)) do_reset($urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
